seg7_scan_ctrl: RTL and testbench
=================================

SEG7_SCAN_CTRL -- requirements
Module: seg7_scan_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 100000, clk cycles per digit slot (min 4).
REQ-002 Parameter BLANK_CYC, default 16, anti-ghost blank cycles at slot start (must be < SCAN_DIV).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 load_valid  input  1  requester offers a new display frame.
REQ-006 load_ready  output  1  block can accept a frame.
REQ-007 load_digits  input  16  four hex nibbles; [3:0] drives digit 0 (AN[0]), [15:12] drives digit 3.
REQ-008 load_dp  input  4  decimal point per digit, 1 = lit.
REQ-009 load_en  input  4  digit enable mask, 0 = digit blanked.
REQ-010 AN  output  4  digit anodes, active-low.
REQ-011 SEG  output  7  segments {g,f,e,d,c,b,a} = SEG[6:0], active-low.
REQ-012 DP  output  1  decimal point, active-low.
REQ-013 frame_tick  output  1  one-cycle pulse at end of each 4-digit frame.

Function
REQ-014 Prescaler counts 0..SCAN_DIV-1 and wraps; slot_end is asserted when the count equals SCAN_DIV-1.
REQ-015 Digit index 0..3 advances on slot_end and wraps 3->0.
REQ-016 frame_tick is 1 for exactly the cycle after slot_end with index 3, otherwise 0.
REQ-017 Two register sets: active (drives display) and shadow; pending flag marks shadow full.
REQ-018 load_ready = !pending, registered; a frame is accepted on a cycle with load_valid && load_ready and captured into shadow; pending set next cycle.
REQ-019 At frame boundary (slot_end && index==3) with pending=1: shadow copied to active and pending cleared; the new frame is shown from digit 0 of the next frame, never mid-frame.
REQ-020 Accept coinciding with a frame boundary: data goes to shadow and applies at the following boundary.
REQ-021 load_valid while load_ready=0 is ignored; the requester holds data until accepted.
REQ-022 AN, SEG, DP are registered: one-cycle latency from prescaler/index state.
REQ-023 While prescaler < BLANK_CYC: AN=4'b1111, SEG=7'h7F, DP=1.
REQ-024 Otherwise, with en[index]=1: AN = one-hot-low for index (0 -> 4'b1110, 3 -> 4'b0111), SEG = decode of active nibble, DP = !dp[index].
REQ-025 With en[index]=0: AN=4'b1111, SEG=7'h7F, DP=1 for the whole slot.
REQ-026 Decode is the full hex table; required values: 0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000, A -> 7'b0001000, F -> 7'b0001110.
REQ-027 At most one AN bit low in any cycle.

Reset
REQ-028 On rst: prescaler 0, index 0, pending 0, active digits 16'h0000, dp 4'h0, en 4'h0.
REQ-029 On rst: AN=4'b1111, SEG=7'h7F, DP=1, frame_tick=0; load_ready=1 from the first cycle after rst deasserts.
REQ-030 rst mid-operation discards any pending shadow frame and restarts scanning at digit 0.

Structure
REQ-031 Shared package holds the 16-entry segment pattern constants, the AN one-hot-low codes, and the blank constants (AN 4'b1111, SEG 7'h7F).
REQ-032 Hex-to-segment decode is a separate combinational sub-module, seg7_decode (4-bit in, 7-bit active-low out).

Verification (SCAN_DIV=8, BLANK_CYC=2)
REQ-033 Reset, then load 16'h1234, dp 4'b0001, en 4'hF -> from the next frame each digit is blank 2 cycles then lit 6 cycles: AN 1110/SEG 0011001 ("4")/DP 0, then 1101 "3", 1011 "2", 0111 "1"; frame_tick every 32 cycles.
REQ-034 Load frame A, then hold load_valid with frame B -> load_ready=0 until A's boundary; B accepted one cycle later and shown one frame after A.
REQ-035 Load with load_valid on the exact slot_end of index 3 -> new data not shown in the next frame, shown in the frame after.
REQ-036 en=4'b0101 with digits 16'h8888 -> AN never drives digits 1 or 3 low; SEG=7'h7F in those slots.
REQ-037 Assert rst mid-slot with a frame pending -> next cycle outputs blank; after release digit 0 scans from prescaler 0 with all-zero active data blanked (en=0); the pending frame is never shown.
REQ-038 All 16 nibble values on digit 0 -> SEG matches the package table; assertion that at most one AN bit is low holds throughout.

Source files
------------

// File: rtl/seg7_scan_ctrl_pkg.sv
// Shared constants for the 4-digit seven-segment scan controller:
// active-low segment patterns, anode select codes and blank levels.
package seg7_scan_ctrl_pkg;

    typedef logic [1:0] digit_idx_t;

    localparam logic [3:0] AN_BLANK  = 4'b1111;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Index 0 is the leftmost element of these packed tables.
    localparam logic [0:3][3:0] AN_CODE = {
        4'b1110, 4'b1101, 4'b1011, 4'b0111
    };

    // {g,f,e,d,c,b,a}, active-low, hex 0..F
    localparam logic [0:15][6:0] SEG_TABLE = {
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

endpackage

// File: rtl/seg7_decode.sv
// Hex nibble to active-low seven-segment pattern, purely combinational.
module seg7_decode
    import seg7_scan_ctrl_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed 4-digit seven-segment driver with a double-buffered
// frame load interface; new frames take effect only at frame boundaries.
module seg7_scan_ctrl
    import seg7_scan_ctrl_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_valid,
    output logic        load_ready,
    input  logic [15:0] load_digits,
    input  logic [3:0]  load_dp,
    input  logic [3:0]  load_en,
    output logic [3:0]  AN,
    output logic [6:0]  SEG,
    output logic        DP,
    output logic        frame_tick
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [CW-1:0] cnt;
    digit_idx_t    idx;
    logic          pending;
    logic [15:0]   act_digits, shd_digits;
    logic [3:0]    act_dp, shd_dp;
    logic [3:0]    act_en, shd_en;

    logic          slot_end;
    logic          frame_end;
    logic          accept;
    logic          lit;
    logic [3:0]    cur_nib;
    logic [6:0]    cur_seg;

    assign slot_end   = (cnt == CW'(SCAN_DIV - 1));
    assign frame_end  = slot_end && (idx == 2'd3);
    assign load_ready = !pending;
    assign accept     = load_valid && load_ready;
    assign cur_nib    = act_digits[{idx, 2'b00} +: 4];
    assign lit        = (cnt >= CW'(BLANK_CYC)) && act_en[idx];

    seg7_decode u_decode (
        .digit (cur_nib),
        .seg   (cur_seg)
    );

    // Scan timing, frame buffering and registered display outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            idx        <= 2'd0;
            pending    <= 1'b0;
            act_digits <= 16'h0000;
            act_dp     <= 4'h0;
            act_en     <= 4'h0;
            frame_tick <= 1'b0;
            AN         <= AN_BLANK;
            SEG        <= SEG_BLANK;
            DP         <= 1'b1;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            if (slot_end)
                idx <= idx + 2'd1;
            frame_tick <= frame_end;

            // Swap only on a frame boundary so a frame is never torn.
            if (frame_end && pending) begin
                act_digits <= shd_digits;
                act_dp     <= shd_dp;
                act_en     <= shd_en;
                pending    <= 1'b0;
            end else if (accept) begin
                pending    <= 1'b1;
            end

            AN  <= lit ? AN_CODE[idx] : AN_BLANK;
            SEG <= lit ? cur_seg      : SEG_BLANK;
            DP  <= lit ? !act_dp[idx] : 1'b1;
        end
    end

    // Shadow holds data only; its validity is tracked by pending.
    always_ff @(posedge clk) begin
        if (accept) begin
            shd_digits <= load_digits;
            shd_dp     <= load_dp;
            shd_en     <= load_en;
        end
    end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl with SCAN_DIV=8, BLANK_CYC=2.
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_digits;
    logic [3:0]  load_dp;
    logic [3:0]  load_en;
    logic [3:0]  AN;
    logic [6:0]  SEG;
    logic        DP;
    logic        frame_tick;

    seg7_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .load_digits (load_digits),
        .load_dp     (load_dp),
        .load_en     (load_en),
        .AN          (AN),
        .SEG         (SEG),
        .DP          (DP),
        .frame_tick  (frame_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
        logic       tick;
        logic       rdy;
        string      name;
    } exp_t;

    exp_t q[$];
    int   cyc    = 0;
    int   base   = 0;
    int   total  = 0;
    int   fails  = 0;

    logic [6:0] seg_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the expectation due this cycle and checks the AN invariant.
    always @(negedge clk) begin
        exp_t e;
        total++;
        if ($countones(~AN) > 1) begin
            fails++;
            $display("FAIL an_onehot cyc=%0d: AN=%b, required at most one low bit", cyc, AN);
        end
        while (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            total++;
            fails++;
            $display("FAIL %s: expectation for cyc %0d never sampled (now %0d)", e.name, e.cyc, cyc);
        end
        if (q.size() > 0 && q[0].cyc == cyc) begin
            e = q.pop_front();
            total++;
            if (AN !== e.an || SEG !== e.seg || DP !== e.dp ||
                frame_tick !== e.tick || load_ready !== e.rdy) begin
                fails++;
                $display("FAIL %s cyc=%0d: got AN=%b SEG=%b DP=%b tick=%b rdy=%b, want AN=%b SEG=%b DP=%b tick=%b rdy=%b",
                         e.name, cyc, AN, SEG, DP, frame_tick, load_ready,
                         e.an, e.seg, e.dp, e.tick, e.rdy);
            end
        end
    end

    // s = state index after reset release (prescaler/index before edge s).
    task automatic expect_at(input int s, input logic [3:0] an, input logic [6:0] seg,
                             input logic dp, input logic tick, input logic rdy,
                             input string nm);
        exp_t e;
        e = '{base + s + 1, an, seg, dp, tick, rdy, nm};
        q.push_back(e);
    endtask

    task automatic blank_at(input int s, input logic tick, input logic rdy, input string nm);
        expect_at(s, 4'b1111, 7'h7F, 1'b1, tick, rdy, nm);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (q.size() > 0) begin
            @(negedge clk);
            n++;
            if (n > 3000) begin
                $display("FAIL drain_timeout: %0d expectations outstanding", q.size());
                $fatal(1, "drain timeout");
            end
        end
    endtask

    task automatic do_reset();
        exp_t e;
        wait_drain();
        rst = 1'b1;
        e = '{cyc + 1, 4'b1111, 7'h7F, 1'b1, 1'b0, 1'b1, "reset_state"};
        q.push_back(e);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        base = cyc;
    endtask

    task automatic wait_state(input int s);
        while (cyc < base + s) @(negedge clk);
    endtask

    task automatic load_at(input int s, input logic [15:0] d, input logic [3:0] p,
                           input logic [3:0] e);
        int n = 0;
        wait_state(s);
        load_digits = d;
        load_dp     = p;
        load_en     = e;
        load_valid  = 1'b1;
        while (!load_ready) begin
            @(negedge clk);
            n++;
            if (n > 200) begin
                $display("FAIL load_timeout: load_ready stayed %b", load_ready);
                $fatal(1, "load timeout");
            end
        end
        @(posedge clk);
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    initial begin
        rst         = 1'b1;
        load_valid  = 1'b0;
        load_digits = 16'h0;
        load_dp     = 4'h0;
        load_en     = 4'h0;
        @(negedge clk);

        // Basic frame 1234, dp on digit 0, all enabled
        do_reset();
        blank_at(0, 1'b0, 1'b1, "s1_idle");
        blank_at(10, 1'b0, 1'b0, "s1_pending");
        blank_at(31, 1'b1, 1'b1, "s1_tick0");
        blank_at(32, 1'b0, 1'b1, "s1_blank0a");
        blank_at(33, 1'b0, 1'b1, "s1_blank0b");
        expect_at(34, 4'b1110, 7'b0011001, 1'b0, 1'b0, 1'b1, "s1_d0_first");
        expect_at(39, 4'b1110, 7'b0011001, 1'b0, 1'b0, 1'b1, "s1_d0_last");
        blank_at(41, 1'b0, 1'b1, "s1_blank1");
        expect_at(42, 4'b1101, 7'b0110000, 1'b1, 1'b0, 1'b1, "s1_d1");
        expect_at(50, 4'b1011, 7'b0100100, 1'b1, 1'b0, 1'b1, "s1_d2");
        expect_at(58, 4'b0111, 7'b1111001, 1'b1, 1'b0, 1'b1, "s1_d3");
        expect_at(62, 4'b0111, 7'b1111001, 1'b1, 1'b0, 1'b1, "s1_d3_pre_tick");
        expect_at(63, 4'b0111, 7'b1111001, 1'b1, 1'b1, 1'b1, "s1_tick1");
        expect_at(95, 4'b0111, 7'b1111001, 1'b1, 1'b1, 1'b1, "s1_tick2");
        load_at(2, 16'h1234, 4'b0001, 4'hF);

        // Back-pressure: frame B held while frame A pending
        do_reset();
        blank_at(4, 1'b0, 1'b0, "s2_busy");
        blank_at(31, 1'b1, 1'b1, "s2_ready_at_boundary");
        blank_at(32, 1'b0, 1'b0, "s2_b_accepted");
        expect_at(34, 4'b1110, 7'b0001000, 1'b1, 1'b0, 1'b0, "s2_frame_a");
        blank_at(42, 1'b0, 1'b0, "s2_d1_disabled");
        blank_at(63, 1'b1, 1'b1, "s2_tick1");
        expect_at(66, 4'b1110, 7'b0001110, 1'b0, 1'b0, 1'b1, "s2_frame_b");
        load_at(2, 16'h000A, 4'b0000, 4'b0001);
        load_at(5, 16'h000F, 4'b0001, 4'b0001);

        // Accept exactly on the frame boundary
        do_reset();
        blank_at(30, 1'b0, 1'b1, "s3_before");
        blank_at(31, 1'b1, 1'b0, "s3_accept_boundary");
        blank_at(34, 1'b0, 1'b0, "s3_not_next_frame");
        blank_at(63, 1'b1, 1'b1, "s3_tick1");
        expect_at(66, 4'b1110, 7'b0000000, 1'b1, 1'b0, 1'b1, "s3_frame_after");
        load_at(31, 16'h0008, 4'b0000, 4'b0001);

        // Enable mask 0101 with 8888
        do_reset();
        expect_at(34, 4'b1110, 7'b0000000, 1'b1, 1'b0, 1'b1, "s4_d0");
        blank_at(42, 1'b0, 1'b1, "s4_d1_off_a");
        blank_at(47, 1'b0, 1'b1, "s4_d1_off_b");
        expect_at(50, 4'b1011, 7'b0000000, 1'b1, 1'b0, 1'b1, "s4_d2");
        blank_at(58, 1'b0, 1'b1, "s4_d3_off_a");
        blank_at(63, 1'b1, 1'b1, "s4_d3_off_b");
        load_at(2, 16'h8888, 4'b0000, 4'b0101);

        // Reset mid-slot with a frame pending
        do_reset();
        blank_at(0, 1'b0, 1'b1, "s5_idle");
        blank_at(10, 1'b0, 1'b0, "s5_pending");
        load_at(2, 16'h0001, 4'hF, 4'hF);
        wait_state(12);
        do_reset();
        blank_at(0, 1'b0, 1'b1, "s5_restart");
        blank_at(2, 1'b0, 1'b1, "s5_d0_blank");
        blank_at(7, 1'b0, 1'b1, "s5_d0_end");
        blank_at(31, 1'b1, 1'b1, "s5_tick0");
        blank_at(34, 1'b0, 1'b1, "s5_never_shown_d0");
        blank_at(35, 1'b0, 1'b1, "s5_never_shown_d0b");
        blank_at(42, 1'b0, 1'b1, "s5_never_shown_d1");
        blank_at(50, 1'b0, 1'b1, "s5_never_shown_d2");
        blank_at(58, 1'b0, 1'b1, "s5_never_shown_d3");

        // All 16 nibbles on digit 0, one per frame
        do_reset();
        for (int n = 0; n < 16; n++)
            expect_at(32 * (n + 1) + 4, 4'b1110, seg_tab[n], 1'b1, 1'b0,
                      (n == 15) ? 1'b1 : 1'b0, $sformatf("s6_nibble_%0h", n));
        for (int n = 0; n < 16; n++)
            load_at((n == 0) ? 2 : 0, {12'h000, 4'(n)}, 4'b0000, 4'b0001);

        wait_drain();
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
